// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: a one- or two-entry pipeline register with valid/ready handshakes.
// With SKID_EN=1 a skid entry catches the payload that arrives in the cycle
// back-pressure begins, so in_ready comes straight from state flops. With
// SKID_EN=0 only the main entry exists and in_ready passes out_ready through.
// A flush clears all held data. A saturating counter records the number of
// back-pressured cycles.
module pipe_skid_reg #(
    parameter int WIDTH   = 64,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;

    // Handshake decode and outputs; every output except in_ready with SKID_EN=0 depends on flops only
    always_comb begin
        out_valid = (state != EMPTY);
        out_data  = main_q;
        if (SKID_EN != 0) begin
            in_ready = (state != FULL);
        end else begin
            in_ready = (state == EMPTY) | out_ready;
        end
        accept = in_valid & in_ready;
        pop    = out_valid & out_ready;
        case (state)
            EMPTY:   occupancy = 2'd0;
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Entry state machine and payload registers; flush overrides any transition
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        main_q <= in_data;
                    end else if (accept && (SKID_EN != 0)) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where a valid output is held back by downstream
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg. Three instances share one stimulus stream:
// skid mode, single-entry mode, and a 2-bit stall counter. Each instance is
// compared every cycle against a small FIFO reference model. A table of
// directed vectors also checks the skid instance against constants.
module tb_pipe_skid_reg;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [63:0] od0, od1, od2;
    logic [1:0]  occ0, occ1, occ2;
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    pipe_skid_reg #(.WIDTH(64), .SKID_EN(1), .CNT_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .flush(flush),
        .occupancy(occ0), .stall_cnt(sc0));

    pipe_skid_reg #(.WIDTH(64), .SKID_EN(0), .CNT_W(16)) dut1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .flush(flush),
        .occupancy(occ1), .stall_cnt(sc1));

    pipe_skid_reg #(.WIDTH(64), .SKID_EN(1), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .flush(flush),
        .occupancy(occ2), .stall_cnt(sc2));

    // Reference model: a FIFO of up to 'cap' entries per instance
    logic [63:0] e [3][2];
    int          n [3];
    int unsigned cnt [3];
    bit          dz [3];
    bit          skid [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned cmax [3] = '{65535, 65535, 3};

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [1:0]  eocc;
        logic        chk_od;
        logic [63:0] eod;
        logic        eir;
        logic [15:0] esc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic iv, logic [63:0] id, logic ordy, logic fl, logic ev,
                                logic [1:0] eocc, logic chk_od, logic [63:0] eod,
                                logic eir, logic [15:0] esc);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.ev = ev; v.eocc = eocc;
        v.chk_od = chk_od; v.eod = eod; v.eir = eir; v.esc = esc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] actual=%h expected=%h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            n[i] = 0;
            cnt[i] = 0;
            dz[i] = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        logic        a_ov [3];
        logic [1:0]  a_occ [3];
        logic [63:0] a_od [3];
        logic [15:0] a_sc [3];
        a_ov = '{ov0, ov1, ov2};
        a_occ = '{occ0, occ1, occ2};
        a_od = '{od0, od1, od2};
        a_sc = '{sc0, sc1, {14'd0, sc2}};
        for (int i = 0; i < 3; i++) begin
            chk("out_valid", i, {63'd0, a_ov[i]}, {63'd0, (n[i] > 0)});
            chk("occupancy", i, {62'd0, a_occ[i]}, 64'(n[i]));
            if (n[i] > 0) chk("out_data", i, a_od[i], e[i][0]);
            else if (dz[i]) chk("out_data_zero", i, a_od[i], 64'd0);
            chk("stall_cnt", i, {48'd0, a_sc[i]}, 64'(cnt[i]));
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, advance model at posedge, check at next negedge
    task automatic step(input logic iv_, input logic [63:0] id_, input logic ordy_, input logic fl_);
        bit   r [3];
        logic a_ir [3];
        in_valid = iv_;
        in_data = id_;
        out_ready = ordy_;
        flush = fl_;
        #1;
        a_ir = '{ir0, ir1, ir2};
        for (int i = 0; i < 3; i++) begin
            r[i] = skid[i] ? (n[i] < 2) : ((n[i] == 0) || ordy_);
            chk("in_ready", i, {63'd0, a_ir[i]}, {63'd0, r[i]});
        end
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            bit pop_m;
            bit acc_m;
            pop_m = (n[i] > 0) && ordy_;
            acc_m = iv_ && r[i];
            if ((n[i] > 0) && !ordy_ && (cnt[i] < cmax[i])) cnt[i]++;
            if (fl_) begin
                n[i] = 0;
                dz[i] = 1'b1;
            end else begin
                if (pop_m) begin
                    e[i][0] = e[i][1];
                    n[i]--;
                end
                if (acc_m) begin
                    e[i][n[i]] = id_;
                    n[i]++;
                    dz[i] = 1'b0;
                end else if (pop_m && n[i] == 0) begin
                    dz[i] = 1'b0;
                end
            end
        end
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", 0, {63'd0, ov0}, 64'd0);
        chk("rst_occupancy", 0, {62'd0, occ0}, 64'd0);
        chk("rst_out_data", 0, od0, 64'd0);
        chk("rst_stall_cnt", 0, {48'd0, sc0}, 64'd0);
        chk("rst_in_ready", 0, {63'd0, ir0}, 64'd1);
        chk("rst_in_ready", 1, {63'd0, ir1}, 64'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Directed table for the skid instance
        for (int k = 1; k <= 8; k++) vt.push_back(mk(1, 64'(k), 1, 0, 1, 1, 1, 64'(k), 1, 0));
        vt.push_back(mk(0, 64'h0, 1, 0, 0, 0, 0, 64'h0, 1, 0));
        vt.push_back(mk(1, 64'hA, 0, 0, 1, 1, 1, 64'hA, 1, 0));
        vt.push_back(mk(1, 64'hB, 0, 0, 1, 2, 1, 64'hA, 0, 1));
        for (int k = 2; k <= 6; k++) vt.push_back(mk(1, 64'hC, 0, 0, 1, 2, 1, 64'hA, 0, 16'(k)));
        vt.push_back(mk(1, 64'hC, 1, 0, 1, 1, 1, 64'hB, 1, 6));
        vt.push_back(mk(1, 64'hC, 1, 0, 1, 1, 1, 64'hC, 1, 6));
        vt.push_back(mk(0, 64'h0, 1, 0, 0, 0, 0, 64'h0, 1, 6));
        vt.push_back(mk(1, 64'hA, 0, 0, 1, 1, 1, 64'hA, 1, 6));
        vt.push_back(mk(1, 64'hB, 0, 0, 1, 2, 1, 64'hA, 0, 7));
        vt.push_back(mk(1, 64'hFF, 1, 1, 0, 0, 1, 64'h0, 1, 7));
        vt.push_back(mk(0, 64'h0, 1, 0, 0, 0, 1, 64'h0, 1, 7));
        vt.push_back(mk(1, 64'h55, 1, 0, 1, 1, 1, 64'h55, 1, 7));
        vt.push_back(mk(0, 64'h0, 1, 0, 0, 0, 0, 64'h0, 1, 7));

        foreach (vt[i]) begin
            step(vt[i].iv, vt[i].id, vt[i].ordy, vt[i].fl);
            chk("tbl_out_valid", i, {63'd0, ov0}, {63'd0, vt[i].ev});
            chk("tbl_occupancy", i, {62'd0, occ0}, {62'd0, vt[i].eocc});
            if (vt[i].chk_od) chk("tbl_out_data", i, od0, vt[i].eod);
            chk("tbl_in_ready", i, {63'd0, ir0}, {63'd0, vt[i].eir});
            chk("tbl_stall_cnt", i, {48'd0, sc0}, {48'd0, vt[i].esc});
        end
        chk("sat_stall_cnt", 2, {62'd0, sc2}, 64'd3);

        // Single-entry instance with out_ready toggling under continuous input
        for (int k = 0; k < 8; k++) step(1, 64'h30 + 64'(k), (k % 2) == 0, 0);
        step(0, 64'h0, 1, 0);
        step(0, 64'h0, 1, 0);

        // Asynchronous reset mid-cycle while FULL
        step(1, 64'hA, 0, 0);
        step(1, 64'hB, 0, 0);
        step(1, 64'hC, 0, 0);
        chk("pre_rst_occupancy", 0, {62'd0, occ0}, 64'd2);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out_valid", 0, {63'd0, ov0}, 64'd0);
        chk("arst_occupancy", 0, {62'd0, occ0}, 64'd0);
        chk("arst_out_data", 0, od0, 64'd0);
        chk("arst_stall_cnt", 0, {48'd0, sc0}, 64'd0);
        chk("arst_in_ready", 0, {63'd0, ir0}, 64'd1);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        step(1, 64'h77, 0, 0);
        chk("post_rst_out_data", 0, od0, 64'h77);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
